// File: rtl/ssd1306_spi4_tx.sv
// SSD1306 4-wire SPI byte transmitter (mode 0, MSB first, CS held across bursts).
// Ports: clk/rst (sync, active-high); tx_valid/tx_ready/tx_data/tx_dc/tx_last
// byte handshake; end_i releases a held CS; busy; cs_o/sck_o/sdo_o/dc_o pins.
module ssd1306_spi4_tx #(
    parameter int CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_dc,
    input  logic       tx_last,
    input  logic       end_i,
    output logic       busy,
    output logic       cs_o,
    output logic       sck_o,
    output logic       sdo_o,
    output logic       dc_o
);

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        HIGH,
        LOW,
        TRAIL,
        HOLD,
        GAP
    } state_t;

    localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

    state_t     state;
    logic [7:0] cnt;
    logic [7:0] shreg;
    logic [2:0] nbit;
    logic       last_q;
    logic       accept;
    logic       cnt_done;

    // tx_ready is only ever high in IDLE and HOLD, so this is the accept point
    assign accept   = tx_valid && tx_ready;
    assign cnt_done = (cnt == 8'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 8'd0;
            shreg    <= 8'd0;
            nbit     <= 3'd0;
            last_q   <= 1'b0;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            cs_o     <= 1'b1;
            sck_o    <= 1'b0;
            sdo_o    <= 1'b0;
            dc_o     <= 1'b0;
        end else if (accept) begin
            // same path from IDLE and HOLD; CS simply stays low from HOLD
            state    <= LEAD;
            cnt      <= RELOAD;
            shreg    <= tx_data;
            nbit     <= 3'd0;
            last_q   <= tx_last;
            tx_ready <= 1'b0;
            busy     <= 1'b1;
            cs_o     <= 1'b0;
            sck_o    <= 1'b0;
            sdo_o    <= tx_data[7];
            dc_o     <= tx_dc;
        end else begin
            unique case (state)
                IDLE: begin
                    cnt <= 8'd0;
                end
                LEAD: begin
                    if (cnt_done) begin
                        state <= HIGH;
                        cnt   <= RELOAD;
                        sck_o <= 1'b1;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                HIGH: begin
                    if (cnt_done) begin
                        cnt   <= RELOAD;
                        sck_o <= 1'b0;
                        if (nbit == 3'd7) begin
                            state <= TRAIL;
                        end else begin
                            // next bit goes out on the falling edge
                            state <= LOW;
                            shreg <= {shreg[6:0], 1'b0};
                            sdo_o <= shreg[6];
                            nbit  <= nbit + 3'd1;
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                LOW: begin
                    if (cnt_done) begin
                        state <= HIGH;
                        cnt   <= RELOAD;
                        sck_o <= 1'b1;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                TRAIL: begin
                    if (cnt_done) begin
                        cnt <= RELOAD;
                        if (last_q) begin
                            state <= GAP;
                            cs_o  <= 1'b1;
                        end else begin
                            state    <= HOLD;
                            tx_ready <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                HOLD: begin
                    if (end_i) begin
                        state    <= GAP;
                        cnt      <= RELOAD;
                        cs_o     <= 1'b1;
                        tx_ready <= 1'b0;
                    end
                end
                GAP: begin
                    // guarantees a minimum CS-high time between frames
                    if (cnt_done) begin
                        state    <= IDLE;
                        tx_ready <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    tx_ready <= 1'b1;
                    busy     <= 1'b0;
                    cs_o     <= 1'b1;
                    sck_o    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ssd1306_spi4_tx.sv
// Testbench for ssd1306_spi4_tx: three instances (CLK_DIV 2, 1, 255) watched
// by a behavioural SPI slave; expected bytes and timings come from the rules.
module tb_ssd1306_spi4_tx;

    logic       clk;
    logic       rst;
    logic [2:0] valid;
    logic [2:0] ready;
    logic [7:0] data;
    logic       dcin;
    logic       lastin;
    logic       end_i;
    logic [2:0] busy;
    logic [2:0] cs;
    logic [2:0] sck;
    logic [2:0] sdo;
    logic [2:0] dc;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // slave-side observations
    int         acc_cyc[3];
    logic       in_byte[3];
    int         end_t[3];
    logic       end_gap[3];
    int         idle_t[3];
    int         cs_rise_t[3];
    int         cs_rise[3];
    int         nrise[3];
    int         viol[3];
    int         rise_t[3][$];
    logic [8:0] rx_q[3][$];
    logic [7:0] sh[3];
    int         nb[3];
    logic       p_sck[3];
    logic       p_sdo[3];
    logic       p_cs[3];
    logic       p_busy[3];

    ssd1306_spi4_tx #(.CLK_DIV(2)) u0 (
        .clk(clk), .rst(rst), .tx_valid(valid[0]), .tx_ready(ready[0]),
        .tx_data(data), .tx_dc(dcin), .tx_last(lastin), .end_i(end_i),
        .busy(busy[0]), .cs_o(cs[0]), .sck_o(sck[0]), .sdo_o(sdo[0]),
        .dc_o(dc[0])
    );
    ssd1306_spi4_tx #(.CLK_DIV(1)) u1 (
        .clk(clk), .rst(rst), .tx_valid(valid[1]), .tx_ready(ready[1]),
        .tx_data(data), .tx_dc(dcin), .tx_last(lastin), .end_i(end_i),
        .busy(busy[1]), .cs_o(cs[1]), .sck_o(sck[1]), .sdo_o(sdo[1]),
        .dc_o(dc[1])
    );
    ssd1306_spi4_tx #(.CLK_DIV(255)) u2 (
        .clk(clk), .rst(rst), .tx_valid(valid[2]), .tx_ready(ready[2]),
        .tx_data(data), .tx_dc(dcin), .tx_last(lastin), .end_i(end_i),
        .busy(busy[2]), .cs_o(cs[2]), .sck_o(sck[2]), .sdo_o(sdo[2]),
        .dc_o(dc[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // SPI slave model: shifts on SCK rise, logs {dc, byte}, drops partials on CS rise
    initial begin
        for (int i = 0; i < 3; i++) begin
            acc_cyc[i] = 0; in_byte[i] = 1'b0; end_t[i] = 0; end_gap[i] = 1'b0;
            idle_t[i] = 0; cs_rise_t[i] = 0; cs_rise[i] = 0; nrise[i] = 0;
            viol[i] = 0; sh[i] = 8'd0; nb[i] = 0;
            p_sck[i] = 1'b0; p_sdo[i] = 1'b0; p_cs[i] = 1'b1; p_busy[i] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (valid[i] && ready[i]) begin
                    acc_cyc[i] = cyc;
                    in_byte[i] = 1'b1;
                end else if (in_byte[i] && (ready[i] || cs[i])) begin
                    in_byte[i] = 1'b0;
                    end_t[i] = cyc - acc_cyc[i];
                    end_gap[i] = cs[i];
                end
                if (sck[i] && !p_sck[i]) begin
                    if (cs[i]) viol[i]++;
                    nrise[i]++;
                    rise_t[i].push_back(cyc - acc_cyc[i]);
                    sh[i] = {sh[i][6:0], sdo[i]};
                    nb[i]++;
                    if (nb[i] == 8) begin
                        rx_q[i].push_back({dc[i], sh[i]});
                        nb[i] = 0;
                    end
                end
                if (!sck[i] && p_sck[i] && p_cs[i]) viol[i]++;
                if (sck[i] && p_sck[i] && (sdo[i] != p_sdo[i])) viol[i]++;
                if (cs[i] && !p_cs[i]) begin
                    nb[i] = 0;
                    cs_rise[i]++;
                    cs_rise_t[i] = cyc - acc_cyc[i];
                end
                if (!busy[i] && p_busy[i]) idle_t[i] = cyc - acc_cyc[i];
                p_sck[i] = sck[i];
                p_sdo[i] = sdo[i];
                p_cs[i] = cs[i];
                p_busy[i] = busy[i];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int i, input logic [7:0] d, input logic c,
                        input logic l);
        int n;
        n = 0;
        while (!ready[i] && n < 6000) begin
            tick();
            n++;
        end
        chk("send_ready", 32'(ready[i]), 32'd1);
        data = d;
        dcin = c;
        lastin = l;
        valid[i] = 1'b1;
        tick();
        valid[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i);
        int n;
        n = 0;
        while (busy[i] && n < 6000) begin
            tick();
            n++;
        end
        tick();
        chk("idle_timeout", 32'(busy[i]), 32'd0);
    endtask

    initial begin : stim
        int         rb;
        int         xb;
        int         cr;
        int         nr;
        int         n;
        int         nlast;
        logic [8:0] exp_q[$];
        logic [7:0] d;
        logic       c;
        logic       l;

        rst = 1'b1;
        valid = 3'b000;
        data = 8'h00;
        dcin = 1'b0;
        lastin = 1'b0;
        end_i = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("rst_cs", 32'(cs[i]), 32'd1);
            chk("rst_sck", 32'(sck[i]), 32'd0);
            chk("rst_ready", 32'(ready[i]), 32'd1);
            chk("rst_busy", 32'(busy[i]), 32'd0);
            chk("rst_sdo_dc", 32'({sdo[i], dc[i]}), 32'd0);
        end

        // single command byte, CLK_DIV=2
        rb = rise_t[0].size();
        xb = rx_q[0].size();
        send(0, 8'hA5, 1'b0, 1'b1);
        wait_idle(0);
        chk("single_nbytes", 32'(rx_q[0].size() - xb), 32'd1);
        chk("single_byte", 32'(rx_q[0][xb]), 32'h0A5);
        chk("single_nrise", 32'(rise_t[0].size() - rb), 32'd8);
        for (int k = 0; k < 8; k++)
            chk("single_rise_t", 32'(rise_t[0][rb + k]), 32'(1 + 2 * (1 + 2 * k)));
        chk("single_end_t", 32'(end_t[0]), 32'd35);
        chk("single_gap", 32'(end_gap[0]), 32'd1);
        chk("single_cs_t", 32'(cs_rise_t[0]), 32'd35);
        chk("single_idle_t", 32'(idle_t[0]), 32'd37);

        // burst under one CS
        xb = rx_q[0].size();
        cr = cs_rise[0];
        nr = nrise[0];
        send(0, 8'hAE, 1'b0, 1'b0);
        send(0, 8'h00, 1'b1, 1'b0);
        send(0, 8'hFF, 1'b1, 1'b1);
        wait_idle(0);
        chk("burst_nbytes", 32'(rx_q[0].size() - xb), 32'd3);
        chk("burst_b0", 32'(rx_q[0][xb]), 32'h0AE);
        chk("burst_b1", 32'(rx_q[0][xb + 1]), 32'h100);
        chk("burst_b2", 32'(rx_q[0][xb + 2]), 32'h1FF);
        chk("burst_nrise", 32'(nrise[0] - nr), 32'd24);
        chk("burst_cs_rises", 32'(cs_rise[0] - cr), 32'd1);

        // hold release; end_i during a transfer is ignored
        xb = rx_q[0].size();
        cr = cs_rise[0];
        send(0, 8'h55, 1'b1, 1'b0);
        end_i = 1'b1;
        repeat (10) tick();
        end_i = 1'b0;
        n = 0;
        while (!ready[0] && n < 200) begin
            tick();
            n++;
        end
        chk("hold_reached", 32'({ready[0], busy[0], cs[0]}), 32'b110);
        repeat (10) tick();
        chk("hold_still", 32'({ready[0], busy[0], cs[0]}), 32'b110);
        data = 8'h66;
        dcin = 1'b0;
        lastin = 1'b0;
        valid[0] = 1'b1;
        end_i = 1'b1;
        tick();
        valid[0] = 1'b0;
        end_i = 1'b0;
        chk("hold_accept_lead", 32'({ready[0], busy[0], cs[0]}), 32'b010);
        n = 0;
        while (!ready[0] && n < 200) begin
            tick();
            n++;
        end
        chk("hold_again", 32'({ready[0], busy[0], cs[0]}), 32'b110);
        chk("hold_no_cs_rise", 32'(cs_rise[0] - cr), 32'd0);
        end_i = 1'b1;
        tick();
        end_i = 1'b0;
        chk("hold_end_gap", 32'({ready[0], busy[0], cs[0]}), 32'b011);
        wait_idle(0);
        chk("hold_bytes", 32'({rx_q[0][xb], rx_q[0][xb + 1]}), 32'({9'h155, 9'h066}));
        chk("hold_cs_rises", 32'(cs_rise[0] - cr), 32'd1);

        // end_i in IDLE is ignored
        end_i = 1'b1;
        tick();
        end_i = 1'b0;
        tick();
        chk("idle_end_i", 32'({ready[0], busy[0], cs[0]}), 32'b101);

        // abort after the 4th rise
        xb = rx_q[0].size();
        nr = nrise[0];
        send(0, 8'hC3, 1'b1, 1'b1);
        n = 0;
        while ((nrise[0] - nr) < 4 && n < 200) begin
            tick();
            n++;
        end
        rst = 1'b1;
        tick();
        chk("abort_cs_sck", 32'({cs[0], sck[0]}), 32'b10);
        chk("abort_ready_busy", 32'({ready[0], busy[0]}), 32'b10);
        rst = 1'b0;
        repeat (40) tick();
        chk("abort_nrise", 32'(nrise[0] - nr), 32'd4);
        chk("abort_discard", 32'(rx_q[0].size() - xb), 32'd0);

        // CLK_DIV=1 and CLK_DIV=255
        for (int i = 1; i < 3; i++) begin
            int dv;
            dv = (i == 1) ? 1 : 255;
            rb = rise_t[i].size();
            xb = rx_q[i].size();
            send(i, 8'h3C, 1'b0, 1'b1);
            wait_idle(i);
            chk("div_byte", 32'(rx_q[i][xb]), 32'h03C);
            chk("div_nrise", 32'(rise_t[i].size() - rb), 32'd8);
            for (int k = 0; k < 8; k++)
                chk("div_rise_t", 32'(rise_t[i][rb + k]), 32'(1 + dv * (1 + 2 * k)));
            chk("div_end_t", 32'(end_t[i]), 32'(1 + 17 * dv));
            chk("div_idle_t", 32'(idle_t[i]), 32'(1 + 18 * dv));
        end

        // randomized frames against a byte-level model
        for (int i = 0; i < 2; i++) begin
            exp_q.delete();
            nlast = 0;
            xb = rx_q[i].size();
            cr = cs_rise[i];
            nr = nrise[i];
            for (int j = 0; j < 8; j++) begin
                d = 8'($urandom_range(0, 255));
                c = 1'($urandom_range(0, 1));
                l = (j == 7) ? 1'b1 : ($urandom_range(0, 3) == 0);
                exp_q.push_back({c, d});
                if (l) nlast++;
                repeat ($urandom_range(0, 3)) tick();
                send(i, d, c, l);
            end
            wait_idle(i);
            chk("rnd_nbytes", 32'(rx_q[i].size() - xb), 32'd8);
            for (int j = 0; j < 8; j++)
                chk("rnd_byte", 32'(rx_q[i][xb + j]), 32'(exp_q[j]));
            chk("rnd_cs_rises", 32'(cs_rise[i] - cr), 32'(nlast));
            chk("rnd_nrise", 32'(nrise[i] - nr), 32'd64);
        end

        for (int i = 0; i < 3; i++)
            chk("pin_protocol", 32'(viol[i]), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
